// File: rtl/grid_char_parser_if.sv
// Stream bundle for grid_char_parser: ASCII bytes in, one-bit cells out.
// The parser holds the slave view; the source/sink side holds the master view.
interface grid_char_parser_if #(
    parameter int COL_W = 12,
    parameter int ROW_W = 12
);
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             o_valid;
    logic             o_ready;
    logic             o_pix;
    logic             o_eol;
    logic [COL_W-1:0] o_col;
    logic [ROW_W-1:0] o_row;

    modport master (
        output s_valid, s_data, s_last, o_ready,
        input  s_ready, o_valid, o_pix, o_eol, o_col, o_row
    );

    modport slave (
        input  s_valid, s_data, s_last, o_ready,
        output s_ready, o_valid, o_pix, o_eol, o_col, o_row
    );
endinterface

// File: rtl/grid_char_parser.sv
// ASCII grid to cell stream: measures row width from the first row,
// enforces it on later rows, emits row-terminator beats, flags done/error.
module grid_char_parser #(
    parameter int MAX_WIDTH = 2048,
    parameter int COL_W     = 12,
    parameter int ROW_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    grid_char_parser_if.slave bus,
    output logic [COL_W-1:0] row_width,
    output logic             width_locked,
    output logic             frame_done,
    output logic             err
);
    typedef enum logic [2:0] {
        S_MEASURE,
        S_STREAM,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [COL_W-1:0] MAX_C = COL_W'(MAX_WIDTH);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] rw_q, rw_d;
    logic             lock_q, lock_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             pend_q, pend_d;
    logic             ov_q, ov_d;
    logic             pix_q, pix_d;
    logic             eol_q, eol_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0] orow_q, orow_d;

    logic             drain, run, acc;
    logic             is_one, is_zero, is_nl, is_cr;
    logic             bad, eol_hit;
    logic [COL_W-1:0] col_nx;
    logic [ROW_W-1:0] row_inc;

    assign drain   = !ov_q || bus.o_ready;
    assign run     = (state_q == S_MEASURE) || (state_q == S_STREAM);
    // terminal states keep draining the source so it never stalls
    assign bus.s_ready = !rst && ((run && drain) ||
                                  (state_q == S_DONE) ||
                                  (state_q == S_ERR));
    assign acc     = bus.s_valid && bus.s_ready;

    assign is_one  = bus.s_data == 8'h40;
    assign is_zero = bus.s_data == 8'h2E;
    assign is_nl   = bus.s_data == 8'h0A;
    assign is_cr   = bus.s_data == 8'h0D;
    assign row_inc = (&row_q) ? row_q : row_q + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_MEASURE;
            col_q   <= '0;
            rw_q    <= '0;
            lock_q  <= 1'b0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            ov_q    <= 1'b0;
            pix_q   <= 1'b0;
            eol_q   <= 1'b0;
            ocol_q  <= '0;
            orow_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rw_q    <= rw_d;
            lock_q  <= lock_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            ov_q    <= ov_d;
            pix_q   <= pix_d;
            eol_q   <= eol_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        rw_d    = rw_q;
        lock_d  = lock_q;
        row_d   = row_q;
        pend_d  = pend_q;
        ov_d    = ov_q && !bus.o_ready;
        pix_d   = pix_q;
        eol_d   = eol_q;
        ocol_d  = ocol_q;
        orow_d  = orow_q;
        bad     = 1'b0;
        eol_hit = 1'b0;
        col_nx  = col_q;

        unique case (state_q)
            S_MEASURE, S_STREAM: begin
                if (acc) begin
                    if (is_one || is_zero) begin
                        if ((state_q == S_MEASURE) ? (col_q == MAX_C)
                                                   : (col_q == rw_q)) begin
                            bad = 1'b1;
                        end else begin
                            ov_d   = 1'b1;
                            pix_d  = is_one;
                            eol_d  = 1'b0;
                            ocol_d = col_q;
                            orow_d = row_q;
                            col_nx = col_q + COL_W'(1);
                        end
                    end else if (is_nl) begin
                        // a newline on an empty row is a blank line: dropped
                        if (col_q != '0) begin
                            if (state_q == S_STREAM && col_q != rw_q) begin
                                bad = 1'b1;
                            end else begin
                                eol_hit = 1'b1;
                                ov_d    = 1'b1;
                                pix_d   = 1'b0;
                                eol_d   = 1'b1;
                                ocol_d  = col_q;
                                orow_d  = row_q;
                                col_nx  = '0;
                                row_d   = row_inc;
                                rw_d    = col_q;
                                lock_d  = 1'b1;
                                state_d = S_STREAM;
                            end
                        end
                    end else if (!is_cr) begin
                        bad = 1'b1;
                    end

                    col_d = col_nx;

                    if (bad) begin
                        state_d = S_ERR;
                    end else if (bus.s_last) begin
                        pend_d = 1'b0;
                        if (eol_hit) begin
                            state_d = S_FLUSH;
                        end else if (col_nx == '0) begin
                            state_d = drain ? S_DONE : S_FLUSH;
                        end else if (state_q == S_MEASURE ||
                                     col_nx == rw_q) begin
                            state_d = S_FLUSH;
                            pend_d  = 1'b1;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
            end
            S_FLUSH: begin
                // pend_q: a synthetic row terminator is still owed
                if (pend_q) begin
                    if (drain) begin
                        ov_d   = 1'b1;
                        pix_d  = 1'b0;
                        eol_d  = 1'b1;
                        ocol_d = col_q;
                        orow_d = row_q;
                        col_d  = '0;
                        row_d  = row_inc;
                        rw_d   = col_q;
                        lock_d = 1'b1;
                        pend_d = 1'b0;
                    end
                end else if (drain) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
            end
            S_ERR: begin
            end
        endcase
    end

    assign bus.o_valid   = ov_q;
    assign bus.o_pix     = pix_q;
    assign bus.o_eol     = eol_q;
    assign bus.o_col     = ocol_q;
    assign bus.o_row     = orow_q;
    assign row_width     = rw_q;
    assign width_locked  = lock_q;
    assign frame_done    = state_q == S_DONE;
    assign err           = state_q == S_ERR;
endmodule

// File: tb/tb_grid_char_parser.sv
// Randomized bench for grid_char_parser against a string-level reference
// that derives the expected beat list, error point and width from the text.
module tb_grid_char_parser;
    localparam int MAXW = 2048;
    localparam int CW   = 12;
    localparam int RW   = 12;

    typedef logic [7:0] u8;
    typedef struct packed {
        logic          pix;
        logic          eol;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] row_width;
    logic          width_locked;
    logic          frame_done;
    logic          err;

    always #5 clk = ~clk;

    grid_char_parser_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    grid_char_parser #(
        .MAX_WIDTH(MAXW),
        .COL_W    (CW),
        .ROW_W    (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .row_width   (row_width),
        .width_locked(width_locked),
        .frame_done  (frame_done),
        .err         (err)
    );

    u8     stim[$];
    beat_t expq[$];
    bit    m_err, m_lock;
    int    m_w, m_erridx;
    int    got_n;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void setstr(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(u8'(s[i]));
    endfunction

    function automatic void push_beat(input bit pix, input bit eol,
                                      input int col, input int row);
        beat_t b;
        b.pix = pix;
        b.eol = eol;
        b.col = CW'(col);
        b.row = RW'(row);
        expq.push_back(b);
    endfunction

    // Reference: walk the text, deciding each byte by the grid rules.
    function automatic void model();
        int col = 0;
        int row = 0;
        int w   = -1;
        bit eolf;
        expq.delete();
        m_err    = 1'b0;
        m_erridx = -1;
        for (int i = 0; i < stim.size(); i++) begin
            u8 c = stim[i];
            eolf = 1'b0;
            if (c == 8'h40 || c == 8'h2E) begin
                if ((w < 0 && col == MAXW) || (w >= 0 && col == w))
                    m_err = 1'b1;
                else begin
                    push_beat(c == 8'h40, 1'b0, col, row);
                    col++;
                end
            end else if (c == 8'h0A) begin
                if (col > 0) begin
                    if (w >= 0 && col != w) m_err = 1'b1;
                    else begin
                        w = col;
                        push_beat(1'b0, 1'b1, col, row);
                        row++;
                        col = 0;
                        eolf = 1'b1;
                    end
                end
            end else if (c != 8'h0D) begin
                m_err = 1'b1;
            end
            if (!m_err && i == stim.size() - 1) begin
                if (!eolf && col != 0) begin
                    if (w < 0 || col == w) begin
                        w = col;
                        push_beat(1'b0, 1'b1, col, row);
                    end else m_err = 1'b1;
                end
            end
            if (m_err) begin
                m_erridx = i;
                break;
            end
        end
        m_lock = (w >= 0);
        m_w    = (w < 0) ? 0 : w;
    endfunction

    task automatic do_reset(input bit check_it);
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
        bus.o_ready = 1'b1;
        #1;
        if (check_it) chk("rst_s_ready", bus.s_ready, 0);
        @(negedge clk);
        #1;
        if (check_it) begin
            chk("rst_o_valid", bus.o_valid, 0);
            chk("rst_o_pix", bus.o_pix, 0);
            chk("rst_o_eol", bus.o_eol, 0);
            chk("rst_o_col", bus.o_col, 0);
            chk("rst_o_row", bus.o_row, 0);
            chk("rst_row_width", row_width, 0);
            chk("rst_locked", width_locked, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_err", err, 0);
        end
        rst = 1'b0;
    endtask

    task automatic run_case(input bit rnd, input bit check_rst);
        int    idx    = 0;
        int    cyc    = 0;
        int    quiet  = 0;
        int    limit  = stim.size() * 8 + 60;
        bit    stalled = 1'b0;
        bit    err_due = 1'b0;
        bit    done_due = 1'b0;
        beat_t held = '0;
        beat_t cur;
        model();
        do_reset(check_rst);
        got_n = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            bus.o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid = (idx < stim.size()) &&
                          (!rnd || $urandom_range(0, 3) != 0);
            bus.s_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
            bus.s_last  = (idx == stim.size() - 1);
            #1;
            cur = {bus.o_pix, bus.o_eol, bus.o_col, bus.o_row};
            chk("err_level", err, err_due);
            chk("done_level", frame_done, done_due);
            if (err_due) chk("s_ready_in_err", bus.s_ready, 1);
            if (stalled) begin
                chk("stall_valid", bus.o_valid, 1);
                chk("stall_hold", cur, held);
            end
            stalled = bus.o_valid && !bus.o_ready;
            held    = cur;
            if (bus.o_valid && bus.o_ready) begin
                if (got_n < expq.size())
                    chk($sformatf("beat%0d", got_n), cur, expq[got_n]);
                else
                    chk("extra_beat", got_n, expq.size());
                got_n++;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (idx == m_erridx) err_due = 1'b1;
                idx++;
            end
            if (!m_err && idx == stim.size() && got_n >= expq.size())
                done_due = 1'b1;
            if (idx == stim.size() && (frame_done || err) && !bus.o_valid)
                quiet++;
            if (quiet > 3) break;
        end
        chk("timeout", cyc < limit, 1);
        chk("n_beats", got_n, expq.size());
        chk("err_final", err, m_err);
        chk("done_final", frame_done, !m_err);
        chk("locked_final", width_locked, m_lock);
        chk("width_final", row_width, m_w);
    endtask

    task automatic rand_grid();
        int w = $urandom_range(1, 6);
        int h = $urandom_range(1, 5);
        bit crlf  = ($urandom_range(0, 3) == 0);
        bit trail = ($urandom_range(0, 1) == 1);
        int mode  = $urandom_range(0, 5);
        int pos;
        u8  ins;
        stim.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++)
                stim.push_back($urandom_range(0, 1) ? 8'h40 : 8'h2E);
            if (crlf) stim.push_back(8'h0D);
            if (r < h - 1 || trail) stim.push_back(8'h0A);
        end
        if (trail && $urandom_range(0, 2) == 0) stim.push_back(8'h0A);
        pos = $urandom_range(0, stim.size() - 1);
        case (mode)
            0: begin
                ins = $urandom_range(0, 1) ? 8'h40 : 8'h0A;
                stim.insert(pos, ins);
            end
            1: if (stim.size() > 1) stim.delete(pos);
            2: stim[pos] = 8'h78;
            default: ;
        endcase
    endtask

    initial begin
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.o_ready = 1'b0;

        setstr("@.@\n.@.\n@@@\n");
        run_case(1'b0, 1'b1);
        chk("tp_full_width", row_width, 3);
        chk("tp_full_beats", got_n, 12);

        setstr("@.@\n.@.\n@@@");
        run_case(1'b0, 1'b0);
        chk("tp_flush_beats", got_n, 12);

        setstr("@@\r\n..\r\n");
        run_case(1'b0, 1'b0);
        chk("tp_crlf_beats", got_n, 6);
        chk("tp_crlf_width", row_width, 2);

        setstr("@@@\n@@\n");
        run_case(1'b0, 1'b0);
        chk("tp_short_err", err, 1);

        setstr("@@\n@@@");
        run_case(1'b0, 1'b0);
        chk("tp_long_err", err, 1);

        setstr("@.@.@\n.@.@.\n@@...\n..@@@\n@.@.@\n");
        run_case(1'b0, 1'b0);
        run_case(1'b1, 1'b0);

        setstr("@.x@\n");
        run_case(1'b0, 1'b0);
        chk("tp_illegal_err", err, 1);
        setstr("@.\n.@\n");
        run_case(1'b1, 1'b1);

        setstr("\n\n@.\r\n.@\n\n");
        run_case(1'b1, 1'b0);

        stim.delete();
        for (int i = 0; i < MAXW; i++) stim.push_back(8'h40);
        stim.push_back(8'h0A);
        run_case(1'b0, 1'b0);
        chk("max_width", row_width, MAXW);

        stim.push_front(8'h2E);
        run_case(1'b0, 1'b0);
        chk("over_max_err", err, 1);

        for (int t = 0; t < 40; t++) begin
            rand_grid();
            run_case(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
